// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache. It returns a combinational hit and data, and refills one line per miss.
// The cache also provides fence.i invalidation and hit/miss performance counters.
module icache_direct_mapped #(
  parameter int unsigned BLOCK_SIZE = 4,
  parameter int unsigned NUM_LINES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             icache_addr,
  output logic [31:0]             icache_data,
  output logic                    icache_hit,
  output logic                    icache_ready,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic [BLOCK_SIZE*8-1:0] mem_data,
  input  logic                    mem_ready,
  input  logic                    mem_fault,
  input  logic                    fence_i,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int unsigned OFFSET_W = $clog2(BLOCK_SIZE);
  localparam int unsigned INDEX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W    = 32 - OFFSET_W - INDEX_W;
  localparam int unsigned LINE_W   = BLOCK_SIZE * 8;
  localparam int unsigned WORDS    = BLOCK_SIZE / 4;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MISS = 1'b1} state_e;

  state_e              r_state;
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [NUM_LINES];
  logic [LINE_W-1:0]   r_data [NUM_LINES];
  logic [TAG_W-1:0]    r_miss_tag;
  logic [INDEX_W-1:0]  r_miss_idx;
  logic                r_flush_pend;
  logic                r_last_vld;
  logic [31:0]         r_last_addr;
  logic [31:0]         r_hit_cnt;
  logic [31:0]         r_miss_cnt;

  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [LINE_W-1:0]   w_line;
  logic                w_idle;
  logic                w_lookup;
  logic                w_miss;
  logic                w_count_hit;
  logic                w_unused_addr;

  assign w_idx    = icache_addr[OFFSET_W +: INDEX_W];
  assign w_tag    = icache_addr[31 -: TAG_W];
  assign w_line   = r_data[w_idx];
  assign w_idle   = (r_state == S_IDLE);
  assign w_lookup = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss   = w_idle && !fence_i && !w_lookup;

  // One count per distinct fetch, not per stall cycle on the same PC.
  assign w_count_hit = !r_last_vld || (icache_addr != r_last_addr);

  assign icache_hit   = w_idle && !fence_i && w_lookup;
  assign icache_ready = w_idle;
  assign mem_req      = rst && (w_miss || (r_state == S_MISS));
  assign mem_addr     = w_idle ? {icache_addr[31:OFFSET_W], {OFFSET_W{1'b0}}}
                               : {r_miss_tag, r_miss_idx, {OFFSET_W{1'b0}}};
  assign hit_cnt      = r_hit_cnt;
  assign miss_cnt     = r_miss_cnt;
  assign w_unused_addr = ^icache_addr[OFFSET_W-1:0];

  generate
    if (WORDS == 1) begin : g_one_word
      assign icache_data = w_line[31:0];
    end else begin : g_multi_word
      localparam int unsigned WSEL_W = OFFSET_W - 2;
      logic [WSEL_W-1:0] w_wsel;
      assign w_wsel      = icache_addr[OFFSET_W-1:2];
      assign icache_data = w_line[{w_wsel, 5'd0} +: 32];
    end
  endgenerate

  // Control state, valid bits and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_miss_tag   <= '0;
      r_miss_idx   <= '0;
      r_flush_pend <= 1'b0;
      r_last_vld   <= 1'b0;
      r_last_addr  <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (fence_i) r_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_state    <= S_MISS;
            r_miss_tag <= w_tag;
            r_miss_idx <= w_idx;
            r_miss_cnt <= r_miss_cnt + 32'd1;
            r_last_vld <= 1'b0;
          end else if (icache_hit) begin
            if (w_count_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
            r_last_vld  <= 1'b1;
            r_last_addr <= icache_addr;
          end
        end
        S_MISS: begin
          if (fence_i) r_flush_pend <= 1'b1;
          if (mem_ready) begin
            // A flush seen at any point during the refill leaves the new line invalid.
            r_state             <= S_IDLE;
            r_flush_pend        <= 1'b0;
            r_valid[r_miss_idx] <= !mem_fault && !fence_i && !r_flush_pend;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if ((r_state == S_MISS) && mem_ready) begin
      r_data[r_miss_idx] <= mem_data;
      r_tag[r_miss_idx]  <= r_miss_tag;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: 4-byte-line instance for the main flows, 16-byte-line instance for word select.
module tb_icache_direct_mapped;

  logic         clk;
  logic         rst;
  logic         rst_b;
  int           n_checks;
  int           n_fail;

  logic [31:0]  a_addr, a_data, a_mem_addr, a_hit_cnt, a_miss_cnt;
  logic         a_hit, a_ready, a_req, a_mem_ready, a_mem_fault, a_fence;
  logic [31:0]  a_mem_data;

  logic [31:0]  b_addr, b_data, b_mem_addr, b_hit_cnt, b_miss_cnt;
  logic         b_hit, b_ready, b_req, b_mem_ready, b_mem_fault, b_fence;
  logic [127:0] b_mem_data;

  icache_direct_mapped #(.BLOCK_SIZE(4), .NUM_LINES(16)) u_dut_a (
    .clk(clk), .rst(rst), .icache_addr(a_addr), .icache_data(a_data),
    .icache_hit(a_hit), .icache_ready(a_ready), .mem_req(a_req), .mem_addr(a_mem_addr),
    .mem_data(a_mem_data), .mem_ready(a_mem_ready), .mem_fault(a_mem_fault),
    .fence_i(a_fence), .hit_cnt(a_hit_cnt), .miss_cnt(a_miss_cnt)
  );

  icache_direct_mapped #(.BLOCK_SIZE(16), .NUM_LINES(16)) u_dut_b (
    .clk(clk), .rst(rst_b), .icache_addr(b_addr), .icache_data(b_data),
    .icache_hit(b_hit), .icache_ready(b_ready), .mem_req(b_req), .mem_addr(b_mem_addr),
    .mem_data(b_mem_data), .mem_ready(b_mem_ready), .mem_fault(b_mem_fault),
    .fence_i(b_fence), .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Miss on a_addr, then a clean refill with d; returns in IDLE one cycle after mem_ready.
  task automatic fill_a(input logic [31:0] addr, input logic [31:0] d);
    a_addr = addr;
    tick();
    a_mem_ready = 1'b1;
    a_mem_data  = d;
    tick();
    a_mem_ready = 1'b0;
    settle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; rst_b = 1'b0;
    a_addr = '0; a_mem_data = '0; a_mem_ready = 1'b0; a_mem_fault = 1'b0; a_fence = 1'b0;
    b_addr = '0; b_mem_data = '0; b_mem_ready = 1'b0; b_mem_fault = 1'b0; b_fence = 1'b0;
    tick(); tick();
    settle();
    chk("rst_hit", 32'(a_hit), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_req", 32'(a_req), 32'd0);
    chk("rst_hit_cnt", a_hit_cnt, 32'd0);
    chk("rst_miss_cnt", a_miss_cnt, 32'd0);

    // Cold fetch
    rst = 1'b1;
    a_addr = 32'h3000_0000;
    settle();
    chk("cold_hit", 32'(a_hit), 32'd0);
    chk("cold_req", 32'(a_req), 32'd1);
    chk("cold_mem_addr", a_mem_addr, 32'h3000_0000);
    tick();
    a_addr = 32'h1234_5678;
    settle();
    chk("miss_ready", 32'(a_ready), 32'd0);
    chk("miss_req", 32'(a_req), 32'd1);
    chk("miss_addr_held", a_mem_addr, 32'h3000_0000);
    chk("miss_cnt1", a_miss_cnt, 32'd1);
    a_addr = 32'h3000_0000;
    a_mem_ready = 1'b1;
    a_mem_data  = 32'h0000_0413;
    settle();
    chk("req_in_ready_cycle", 32'(a_req), 32'd1);
    tick();
    a_mem_ready = 1'b0;
    settle();
    chk("fill_hit", 32'(a_hit), 32'd1);
    chk("fill_data", a_data, 32'h0000_0413);
    chk("fill_ready", 32'(a_ready), 32'd1);
    chk("fill_req", 32'(a_req), 32'd0);
    tick();
    tick();
    chk("stall_hit_cnt", a_hit_cnt, 32'd1);

    // Conflict on index 0
    a_addr = 32'h3000_0040;
    settle();
    chk("conf_hit", 32'(a_hit), 32'd0);
    chk("conf_req", 32'(a_req), 32'd1);
    fill_a(32'h3000_0040, 32'hAAAA_0040);
    chk("conf_data", a_data, 32'hAAAA_0040);
    tick();
    a_addr = 32'h3000_0000;
    settle();
    chk("evicted_hit", 32'(a_hit), 32'd0);
    fill_a(32'h3000_0000, 32'h0000_0413);
    chk("conf_miss_cnt", a_miss_cnt, 32'd3);
    tick();
    chk("conf_hit_cnt", a_hit_cnt, 32'd3);

    // Alternating hits on two lines count each fetch
    fill_a(32'h3000_0004, 32'hBBBB_0004);
    tick();
    a_addr = 32'h3000_0000;
    settle();
    chk("alt_data0", a_data, 32'h0000_0413);
    tick();
    a_addr = 32'h3000_0004;
    tick();
    chk("alt_hit_cnt", a_hit_cnt, 32'd6);
    chk("alt_miss_cnt", a_miss_cnt, 32'd4);

    // Faulting refill leaves the line invalid
    a_addr = 32'h3000_0010;
    tick();
    a_mem_ready = 1'b1; a_mem_fault = 1'b1; a_mem_data = 32'hDEAD_BEEF;
    tick();
    a_mem_ready = 1'b0; a_mem_fault = 1'b0;
    settle();
    chk("fault_ready", 32'(a_ready), 32'd1);
    chk("fault_hit", 32'(a_hit), 32'd0);
    chk("fault_req", 32'(a_req), 32'd1);
    chk("fault_mem_addr", a_mem_addr, 32'h3000_0010);
    fill_a(32'h3000_0010, 32'h0000_0010);
    chk("refetch_data", a_data, 32'h0000_0010);
    tick();

    // mem_ready while idle must not write anything
    a_addr = 32'h3000_0000;
    a_mem_ready = 1'b1; a_mem_data = 32'hFFFF_FFFF;
    tick();
    a_mem_ready = 1'b0;
    settle();
    chk("idle_rdy_data0", a_data, 32'h0000_0413);
    chk("idle_rdy_ready", 32'(a_ready), 32'd1);
    a_addr = 32'h3000_0010;
    settle();
    chk("idle_rdy_hit10", 32'(a_hit), 32'd1);
    chk("idle_rdy_data10", a_data, 32'h0000_0010);
    tick();
    chk("mid_hit_cnt", a_hit_cnt, 32'd9);
    chk("mid_miss_cnt", a_miss_cnt, 32'd6);

    // fence_i coincident with mem_ready
    a_addr = 32'h3000_0020;
    tick();
    a_mem_ready = 1'b1; a_fence = 1'b1; a_mem_data = 32'h0000_0020;
    tick();
    a_mem_ready = 1'b0; a_fence = 1'b0;
    settle();
    chk("flush_rdy_ready", 32'(a_ready), 32'd1);
    chk("flush_rdy_hit", 32'(a_hit), 32'd0);
    chk("flush_rdy_req", 32'(a_req), 32'd1);
    fill_a(32'h3000_0020, 32'h0000_0020);
    chk("refill20_hit", 32'(a_hit), 32'd1);
    tick();
    fill_a(32'h3000_0000, 32'h0000_0413);
    tick();

    // fence_i in IDLE after two fills
    a_fence = 1'b1;
    settle();
    chk("fence_hit_forced", 32'(a_hit), 32'd0);
    chk("fence_req", 32'(a_req), 32'd0);
    chk("fence_ready", 32'(a_ready), 32'd1);
    tick();
    a_fence = 1'b0;
    settle();
    chk("fence_line0_miss", 32'(a_hit), 32'd0);
    a_addr = 32'h3000_0020;
    settle();
    chk("fence_line8_miss", 32'(a_hit), 32'd0);
    chk("fence_line8_req", 32'(a_req), 32'd1);
    chk("fence_hit_cnt", a_hit_cnt, 32'd11);
    chk("fence_miss_cnt", a_miss_cnt, 32'd9);

    // Reset in the middle of a miss
    tick();
    chk("pre_rst_ready", 32'(a_ready), 32'd0);
    rst = 1'b0;
    settle();
    chk("midrst_ready", 32'(a_ready), 32'd1);
    chk("midrst_req", 32'(a_req), 32'd0);
    chk("midrst_hit", 32'(a_hit), 32'd0);
    chk("midrst_hit_cnt", a_hit_cnt, 32'd0);
    chk("midrst_miss_cnt", a_miss_cnt, 32'd0);
    tick();
    rst = 1'b1; a_fence = 1'b1; a_mem_ready = 1'b1; a_mem_data = 32'h0000_0020;
    tick();
    a_fence = 1'b0; a_mem_ready = 1'b0;
    settle();
    chk("late_rdy_hit", 32'(a_hit), 32'd0);
    chk("late_rdy_ready", 32'(a_ready), 32'd1);
    chk("late_rdy_miss_cnt", a_miss_cnt, 32'd0);

    // 16-byte lines: word select within a refilled line
    rst_b = 1'b1;
    b_addr = 32'hA000_0000;
    settle();
    chk("b_req", 32'(b_req), 32'd1);
    chk("b_mem_addr", b_mem_addr, 32'hA000_0000);
    tick();
    b_addr = 32'hA000_0008;
    settle();
    chk("b_mem_addr_held", b_mem_addr, 32'hA000_0000);
    b_mem_ready = 1'b1;
    b_mem_data  = 128'h0030_0193_0020_0113_0010_0093_0000_0013;
    tick();
    b_mem_ready = 1'b0;
    b_addr = 32'hA000_0004;
    settle();
    chk("b_w1_hit", 32'(b_hit), 32'd1);
    chk("b_w1_data", b_data, 32'h0010_0093);
    chk("b_w1_req", 32'(b_req), 32'd0);
    b_addr = 32'hA000_0008;
    settle();
    chk("b_w2_data", b_data, 32'h0020_0113);
    b_addr = 32'hA000_000C;
    settle();
    chk("b_w3_hit", 32'(b_hit), 32'd1);
    chk("b_w3_data", b_data, 32'h0030_0193);
    chk("b_w3_req", 32'(b_req), 32'd0);
    b_addr = 32'hA000_0000;
    settle();
    chk("b_w0_data", b_data, 32'h0000_0013);
    chk("b_miss_cnt", b_miss_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
